// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, supported oversampling ratios and
// parity type encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam int PS_8  = 8;
  localparam int PS_16 = 16;
  localparam int PS_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Takes three samples around the bit centre (half-1, half, half+1) and presents
// their majority; the vote is stable from edge_cnt == half+2 to the bit end.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      rx,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] half,
  output logic                      bit_val
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [2:0] smp;
  logic       take;

  assign take = en && ((edge_cnt == half - ONE) ||
                       (edge_cnt == half)       ||
                       (edge_cnt == half + ONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) smp <= '0;
    else if (take) smp <= {smp[1:0], rx};
  end

  assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start/data/parity/stop recovery with parity and stop
// checks; a good byte is presented on P_DATA with a one-cycle data_valid strobe.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RX_IN,
  input  logic                      par_en,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [FRAME_WIDTH-1:0]    P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BCW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [BCW-1:0]            LAST = BCW'(FRAME_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE  = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] TWO  = PRESCALE_WIDTH'(2);

  rx_state_e                 state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] ps_q;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [BCW-1:0]            bit_cnt;
  logic [FRAME_WIDTH-1:0]    data_sr;
  logic                      pen_q;
  logic                      ptyp_q;
  logic                      par_bit;
  logic                      bit_val;
  logic                      bit_end;
  logic                      stop_pt;
  logic                      par_bad;

  assign half    = {1'b0, ps_q[PRESCALE_WIDTH-1:1]};
  assign bit_end = (edge_cnt == ps_q - ONE);
  assign stop_pt = (edge_cnt == half + TWO);
  assign par_bad = pen_q && (par_bit != ((ptyp_q == PAR_ODD) ? ~^data_sr : ^data_sr));

  uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .en       (state != IDLE),
    .rx       (RX_IN),
    .edge_cnt (edge_cnt),
    .half     (half),
    .bit_val  (bit_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      ps_q       <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      par_bit    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      edge_cnt   <= bit_end ? '0 : edge_cnt + ONE;
      case (state)
        IDLE: begin
          // Frame configuration is frozen here for the whole frame.
          ps_q     <= Prescale;
          pen_q    <= par_en;
          ptyp_q   <= PAR_TYP;
          bit_cnt  <= '0;
          edge_cnt <= '0;
          if (!RX_IN) begin
            state    <= START;
            edge_cnt <= ONE;
          end
        end
        START: if (bit_end) state <= bit_val ? IDLE : DATA;
        DATA: if (bit_end) begin
          data_sr[bit_cnt] <= bit_val;
          if (bit_cnt == LAST) state <= pen_q ? PARITY : STOP;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (bit_end) begin
          par_bit <= bit_val;
          state   <= STOP;
        end
        // Decide at the stop-bit centre so a back-to-back start edge is not missed;
        // bit_end is a backstop for prescale values where the centre point never occurs.
        STOP: if (stop_pt || bit_end) begin
          state <= DONE;
          if (par_bad) par_err <= 1'b1;
          else if (!bit_val) stp_err <= 1'b1;
          else begin
            data_valid <= 1'b1;
            P_DATA     <= data_sr;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit, the expected strobe,
// byte and latency are queued at issue time and checked by a negedge monitor.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int FW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          RX_IN = 1'b1;
  logic          par_en = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic [FW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_frame #(.FRAME_WIDTH(FW), .PRESCALE_WIDTH(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .par_en     (par_en),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = data_valid, 1 = par_err, 2 = stp_err
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lat;
    int         start;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    n = 32'(data_valid) + 32'(par_err) + 32'(stp_err);
    if (n > 0) begin
      chk("one_strobe", n, 1);
      kind = data_valid ? 0 : (par_err ? 1 : 2);
      if (q.size() == 0) begin
        chk("spurious_strobe", kind + 1, 0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("p_data", int'(P_DATA), int'(e.data));
        chk("latency", cyc - e.start, e.lat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a posedge; gbit/ps/2 flips the middle sample only.
  task automatic send(input logic [7:0] d, input int ps, input logic pen, input logic ptyp,
                      input logic pbit, input logic sbit, input int gbit,
                      input int kind, input logic [7:0] exp_d, input int lat);
    int nb;
    Prescale = PW'(ps);
    par_en   = pen;
    PAR_TYP  = ptyp;
    q.push_back('{kind, exp_d, lat, cyc});
    nb = pen ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      logic v;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (pen && b == 9) v = pbit;
      else v = sbit;
      for (int c = 0; c < ps; c++) begin
        RX_IN = (b == gbit && c == ps / 2) ? ~v : v;
        @(posedge clk);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p_data"}, int'(P_DATA), 0);
    chk({tag, "_data_valid"}, int'(data_valid), 0);
    chk({tag, "_par_err"}, int'(par_err), 0);
    chk({tag, "_stp_err"}, int'(stp_err), 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(3);

    // 1: Prescale 8, no parity
    send(8'hA5, PS_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, 8'hA5, 79);
    idle(4);

    // 2: Prescale 16, even parity good then bad
    send(8'h3C, PS_16, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 0, 8'h3C, 171);
    idle(4);
    send(8'h3C, PS_16, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, 1, 8'h3C, 171);
    idle(4);

    // 3: Prescale 32, odd parity correct, stop bit 0
    send(8'h00, PS_32, 1'b1, PAR_ODD, 1'b1, 1'b0, -1, 2, 8'h3C, 339);
    idle(96);

    // 4: short low pulse on idle line, then a good frame
    Prescale = PW'(PS_16);
    par_en   = 1'b0;
    RX_IN    = 1'b0;
    idle(4);
    RX_IN = 1'b1;
    idle(40);
    send(8'h5A, PS_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, 8'h5A, 155);
    idle(4);

    // 5: back-to-back frames, second with a one-sample glitch in data bit 2
    send(8'h12, PS_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, 8'h12, 79);
    send(8'h34, PS_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3, 0, 8'h34, 79);
    idle(4);
    chk("queue_drained", q.size(), 0);

    // 6: reset in the middle of data bit 4
    Prescale = PW'(PS_8);
    RX_IN    = 1'b0;
    idle(8);
    RX_IN = 1'b1;
    idle(4 * 8 + 4);
    reset = 1'b0;
    #2 chk_reset_outputs("midreset");
    idle(3);
    reset = 1'b1;
    idle(4);
    send(8'hFF, PS_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 0, 8'hFF, 79);
    idle(4);
    send(8'h81, PS_16, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 0, 8'h81, 171);
    idle(8);

    chk("pending", q.size(), 0);
    chk("final_p_data", int'(P_DATA), 8'h81);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
